// File: rtl/riscv_pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: slice load enables,
// per-slice valid tracking, stall/redirect resolution and a saturating stall counter.
module riscv_pipeline_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic                      ex_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_busy,
    input  logic                      ex_redirect,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_en,
    output logic                      ifid_en,
    output logic                      idex_en,
    output logic                      exmem_en,
    output logic                      memwb_en,
    output logic                      ifid_valid,
    output logic                      idex_valid,
    output logic                      exmem_valid,
    output logic                      memwb_valid,
    output logic                      stall,
    output logic [CNT_WIDTH-1:0]      stall_cycles
);

    logic v1_q, v2_q, v3_q, v4_q;
    logic v1_d, v2_d, v3_d, v4_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

    logic mem_stall, ex_stall, redir, lu_stall, rs_match;
    logic f1, f2, f3;

    // Older stages win: a waiting memory access masks everything behind it,
    // and a redirect makes the load-use hazard in ID irrelevant.
    always_comb begin
        mem_stall = v3_q & mem_req & ~mem_ready;
        ex_stall  = v2_q & ex_busy & ~mem_stall;
        redir     = v2_q & ex_redirect & ~mem_stall & ~ex_stall;
        rs_match  = (id_rs1_used & (id_rs1_addr == ex_rd_addr))
                  | (id_rs2_used & (id_rs2_addr == ex_rd_addr));
        lu_stall  = v1_q & v2_q & ex_is_load & (ex_rd_addr != '0) & rs_match
                  & ~mem_stall & ~ex_stall & ~redir;
        f1 = mem_stall | ex_stall | lu_stall;
        f2 = mem_stall | ex_stall;
        f3 = mem_stall;
    end

    always_comb begin
        pc_en    = ~f1 & (if_valid | redir);
        ifid_en  = ~f1;
        idex_en  = ~f2;
        exmem_en = ~f3;
        memwb_en = 1'b1;
        stall    = f1;
    end

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        v4_d = v4_q;
        stall_cycles_d = stall_cycles_q;

        if (f1)         v1_d = v1_q;
        else if (redir) v1_d = 1'b0;
        else            v1_d = if_valid;

        if (f2)                    v2_d = v2_q;
        else if (redir | lu_stall) v2_d = 1'b0;
        else                       v2_d = v1_q;

        if (f3)            v3_d = v3_q;
        else if (ex_stall) v3_d = 1'b0;
        else               v3_d = v2_q;

        if (mem_stall) v4_d = 1'b0;
        else           v4_d = v3_q;

        if (f1 && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q           <= 1'b0;
            v2_q           <= 1'b0;
            v3_q           <= 1'b0;
            v4_q           <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            v1_q           <= v1_d;
            v2_q           <= v2_d;
            v3_q           <= v3_d;
            v4_q           <= v4_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign ifid_valid   = v1_q;
    assign idex_valid   = v2_q;
    assign exmem_valid  = v3_q;
    assign memwb_valid  = v4_q;
    assign stall_cycles = stall_cycles_q;

endmodule
